// File: rtl/ex_muldiv_unit_pkg.sv
// Shared EX-stage pipeline package: ALU control codes, multiply/divide op codes
// and the multiply/divide FSM state encodings.
package ex_muldiv_unit_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add multiply
// or restoring shift-subtract divide, purely combinational.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic [XLEN:0] rem_sel;
  logic          fits;
  logic          unused_rem_msb;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, LSB first.
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: upper half is the partial remainder, low half the dividend/quotient.
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    fits    = (shifted >= {1'b0, opnd});
    rem_sel = fits ? diff : shifted;

    if (is_div) begin
      acc_next = {rem_sel[XLEN-1:0], acc[XLEN-2:0], fits};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  // The remainder never exceeds XLEN bits, so its top bit is always zero.
  assign unused_rem_msb = rem_sel[XLEN];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; fixed XLEN+2 cycle
// latency from accepted start to the done pulse.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_unit_if.slave mdu
);

  localparam int              CNT_W    = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_wide_if(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [2*XLEN-1:0] acc_q,     acc_d;
  logic [XLEN-1:0]   opnd_q,    opnd_d;
  logic              is_div_q,  is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   hi_q,      hi_d;
  logic [XLEN-1:0]   lo_q,      lo_d;

  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic              sgn_op;
  logic              a_neg;
  logic              b_neg;
  logic              b_zero;
  logic              accept;

  muldiv_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div   (is_div_q),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .acc_next (acc_step)
  );

  always_comb begin
    sgn_op = op_is_signed(mdu.op);
    a_neg  = sgn_op & mdu.a[XLEN-1];
    b_neg  = sgn_op & mdu.b[XLEN-1];
    b_zero = (mdu.b == '0);
    accept = mdu.start && !mdu.flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Sign correction of the unsigned magnitude result, applied in FIX.
    prod_fix = neg_wide_if(acc_q, neg_res_q);
    quo_fix  = neg_if(acc_q[XLEN-1:0], neg_res_q);
    rem_fix  = neg_if(acc_q[2*XLEN-1:XLEN], neg_rem_q);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (mdu.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            is_div_d = op_is_div(mdu.op);
            // A zero divisor keeps the all-ones quotient and leaves hi equal to a.
            neg_res_d = op_is_div(mdu.op) ? ((a_neg ^ b_neg) & ~b_zero) : (a_neg ^ b_neg);
            neg_rem_d = op_is_div(mdu.op) & a_neg;
            acc_d     = {{XLEN{1'b0}}, abs_val(mdu.a, sgn_op)};
            opnd_d    = abs_val(mdu.b, sgn_op);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_d = acc_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          state_d = ST_DONE;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*XLEN-1:XLEN];
            lo_d = prod_fix[XLEN-1:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign mdu.busy = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign mdu.done = (state_q == ST_DONE);
  assign mdu.hi   = hi_q;
  assign mdu.lo   = lo_q;

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, giving the operand and HI/LO width.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only when busy=0.
REQ-005 Port op, input, 2 bits: operation select, where 00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
REQ-006 Port a, input, XLEN bits: rs operand (multiplicand or dividend).
REQ-007 Port b, input, XLEN bits: rt operand (multiplier or divisor).
REQ-008 Port flush, input, 1 bit: pipeline flush that aborts any in-flight operation.
REQ-009 Port busy, output, 1 bit: high while an operation is in flight; the hazard unit stalls mfhi/mflo on busy.
REQ-010 Port done, output, 1 bit: single-cycle pulse marking a completed result.
REQ-011 Port hi, output, XLEN bits: HI register (high product or remainder).
REQ-012 Port lo, output, XLEN bits: LO register (low product or quotient).

Function
REQ-013 The FSM SHALL have the states IDLE, RUN, FIX and DONE.
REQ-014 In IDLE or DONE with start=1 and flush=0, the module SHALL latch op, |a| and |b| (signed ops) or a and b (unsigned ops), plus the result signs, then enter RUN with a step counter of 0.
REQ-015 RUN SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 After exactly XLEN RUN cycles (counter = XLEN-1), the FSM SHALL enter FIX.
REQ-017 FIX SHALL apply sign correction as follows.
- MULT: negate the 2*XLEN product if the operand signs differ.
- DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
REQ-018 On the FIX→DONE edge, hi and lo SHALL load the corrected result, and done SHALL be 1 for the DONE cycle only.
REQ-019 DONE SHALL go to IDLE the next cycle unless a new start is accepted (REQ-014).
REQ-020 Latency SHALL be fixed: start high in cycle 0 gives done high in cycle XLEN+2 (34 for XLEN=32), with no data-dependent early exit.
REQ-021 busy SHALL be 1 exactly in RUN and FIX.
REQ-022 start while busy=1 SHALL be ignored, with no queuing.
REQ-023 Divide by zero (b=0) SHALL give lo = all ones and hi = a, unmodified by the sign fix, with the normal latency.
REQ-024 Signed overflow (DIV of most-negative by -1) SHALL give lo = most-negative and hi = 0.
REQ-025 flush=1 in any state SHALL force IDLE on the next edge, with busy=0 and done=0 and hi/lo unchanged; flush takes priority over start in the same cycle.
REQ-026 flush coincident with the FIX→DONE edge SHALL suppress the hi/lo update.
REQ-027 hi and lo SHALL change only on the FIX→DONE edge or on reset.

Reset
REQ-028 While rst=1, state SHALL be IDLE and busy, done, hi, lo, the step counter and the internal accumulators SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard the operation, and no done pulse SHALL follow.
REQ-030 After rst deasserts, the first start SHALL be accepted on the first clk edge.

Structure
REQ-031 The op encodings (MULT/MULTU/DIV/DIVU) and the FSM state encodings SHALL live in the shared pipeline package next to the ALU control codes, as named constants.
REQ-032 The datapath SHALL be a single sub-module, muldiv_step, that is combinational and computes one shift-add or shift-subtract step; the FSM, counter and HI/LO registers SHALL stay in ex_muldiv_unit.
REQ-033 The implementation SHALL use no vendor multiplier or divider macros.

Verification
REQ-034 The bench SHALL cover these directed scenarios.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678; DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start pulsed again during RUN → ignored, and a single done appears in cycle 34 carrying the first result.
- Flush asserted in cycle 10, or rst in cycle 20 → busy=0 the next cycle, no done pulse, hi/lo unchanged (0 after rst).
- Back-to-back start in the DONE cycle → accepted, with a second done 34 cycles later.
